// File: rtl/dispatch8_rr_pkg.sv
// rtl/dispatch8_rr_pkg.sv - shared constants, state encoding and pick helper for dispatch8_rr
package dispatch8_rr_pkg;

  localparam int NUM_DST = 8;
  localparam int SEL_W   = 3;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [SEL_W-1:0] first_set(input logic [NUM_DST-1:0] v);
    logic [SEL_W-1:0] r;
    r = '0;
    for (int i = NUM_DST - 1; i >= 0; i--) begin
      if (v[i]) r = i[SEL_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/demux1to8.sv
// rtl/demux1to8.sv - one-bit 1-to-8 demultiplexer
module demux1to8 (
  input  logic       din,
  input  logic [2:0] s,
  output logic [7:0] y
);

  always_comb begin
    y    = '0;
    y[s] = din;
  end

endmodule

// File: rtl/dff.sv
// rtl/dff.sv - enabled D flip-flop cell with synchronous active-high reset
module dff #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst)     q <= RST_VAL;
    else if (en) q <= d;
  end

endmodule

// File: rtl/rr_pick8.sv
// rtl/rr_pick8.sv - combinational round-robin pick over eight requesters
module rr_pick8
  import dispatch8_rr_pkg::*;
(
  input  logic [NUM_DST-1:0] elig,
  input  logic [SEL_W-1:0]   ptr,
  output logic               any,
  output logic [SEL_W-1:0]   idx
);

  logic [NUM_DST-1:0] rot;

  // Rotate so that bit 0 is the port at ptr; 3-bit index arithmetic wraps mod 8.
  always_comb begin
    rot = '0;
    for (int i = 0; i < NUM_DST; i++) begin
      rot[i] = elig[SEL_W'(i) + ptr];
    end
  end

  assign any = |elig;
  assign idx = ptr + first_set(rot);

endmodule

// File: rtl/dispatch8_rr.sv
// rtl/dispatch8_rr.sv - round-robin one-to-eight dispatcher with holding register and stall timeout
module dispatch8_rr
  import dispatch8_rr_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int STALL_MAX = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [NUM_DST-1:0] dst_ready,
  input  logic [NUM_DST-1:0] dst_en,
  output logic [NUM_DST-1:0] out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   sel,
  output logic               busy,
  output logic               err
);

  localparam logic [7:0] STALL_LIM = 8'(STALL_MAX);

  logic               state_q, state_d, full;
  logic [SEL_W-1:0]   ptr_q, idx;
  logic [7:0]         cnt_q, cnt_d, cnt_inc;
  logic               err_q, err_d;
  logic [NUM_DST-1:0] elig;
  logic               any, go, capture, stalled;

  assign full = (state_q == FULL);
  assign elig = dst_ready & dst_en;

  rr_pick8 u_pick (
    .elig (elig),
    .ptr  (ptr_q),
    .any  (any),
    .idx  (idx)
  );

  // Gating with rst keeps the reset cycle free of any transfer strobe.
  assign go       = full & any & ~rst;
  assign sel      = go ? idx : '0;
  assign in_ready = ~full | go;
  assign capture  = in_valid & in_ready;
  assign stalled  = full & ~go;

  demux1to8 u_demux (
    .din (go),
    .s   (sel),
    .y   (out_valid)
  );

  assign state_d = (capture | stalled) ? FULL : EMPTY;

  dff #(.W(1)) u_state (
    .clk (clk), .rst (rst), .en (1'b1), .d (state_d), .q (state_q)
  );

  dff #(.W(WIDTH)) u_hold (
    .clk (clk), .rst (rst), .en (capture), .d (in_data), .q (out_data)
  );

  dff #(.W(SEL_W)) u_ptr (
    .clk (clk), .rst (rst), .en (go), .d (idx + 3'd1), .q (ptr_q)
  );

  assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
  assign cnt_d   = stalled ? cnt_inc : 8'd0;
  // err rises on the edge that ends the STALL_MAX-th consecutive stalled cycle.
  assign err_d   = err_q | (stalled & (cnt_inc == STALL_LIM));

  dff #(.W(8)) u_cnt (
    .clk (clk), .rst (rst), .en (1'b1), .d (cnt_d), .q (cnt_q)
  );

  dff #(.W(1)) u_err (
    .clk (clk), .rst (rst), .en (1'b1), .d (err_d), .q (err_q)
  );

  assign busy = full;
  assign err  = err_q;

endmodule

// File: tb/tb_dispatch8_rr.sv
// tb/tb_dispatch8_rr.sv - directed scoreboard bench for dispatch8_rr
module tb_dispatch8_rr;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [7:0]  dst_ready;
  logic [7:0]  dst_en;
  logic [7:0]  out_valid;
  logic [15:0] out_data;
  logic [2:0]  sel;
  logic        busy;
  logic        err;

  int errors = 0;
  int checks = 0;

  int          exp_port[$];
  logic [15:0] exp_data[$];
  int          mp;
  logic [15:0] md;

  dispatch8_rr #(.WIDTH(16), .STALL_MAX(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .dst_ready (dst_ready),
    .dst_en    (dst_en),
    .out_valid (out_valid),
    .out_data  (out_data),
    .sel       (sel),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int p, input logic [15:0] d);
    exp_port.push_back(p);
    exp_data.push_back(d);
  endtask

  always @(negedge clk) begin
    if (out_valid !== 8'h00) begin
      if (exp_port.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid got=%0h want=none", out_valid);
      end else begin
        mp = exp_port.pop_front();
        md = exp_data.pop_front();
        check("out_valid", {24'h0, out_valid}, 32'h1 << mp);
        check("sel", {29'h0, sel}, mp);
        check("out_data", {16'h0, out_data}, {16'h0, md});
      end
    end else begin
      check("sel_idle", {29'h0, sel}, 32'h0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0;
    dst_ready = 8'hFF; dst_en = 8'hFF;
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_data", out_data, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_err", err, 0);

    // single word to port 0
    rst = 1'b0; in_valid = 1'b1; in_data = 16'hA5A5; push(0, 16'hA5A5);
    tick();
    in_valid = 1'b0;
    check("single_busy", busy, 1);
    tick();

    // rotation from a fresh pointer
    rst = 1'b1; tick(); rst = 1'b0;
    for (int k = 0; k < 9; k++) begin
      in_valid = 1'b1; in_data = 16'h1000 + 16'(k); push(k % 8, 16'h1000 + 16'(k));
      check("rot_in_ready", in_ready, 1);
      tick();
    end
    in_valid = 1'b0;
    tick();

    // skip: ptr=1 -> port 1, then ptr=2 with only 0 and 7 ready -> port 7, wrap -> port 0
    in_valid = 1'b1; in_data = 16'h2001; push(1, 16'h2001);
    tick();
    in_data = 16'h2002; push(7, 16'h2002);
    tick();
    in_valid = 1'b0; dst_ready = 8'b1000_0001;
    tick();
    in_valid = 1'b1; in_data = 16'h2003; push(0, 16'h2003);
    tick();
    in_valid = 1'b0;
    tick();

    // mask: only port 4 enabled
    dst_ready = 8'hFF; dst_en = 8'h10;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = 16'h4000 + 16'(k); push(4, 16'h4000 + 16'(k));
      tick();
    end
    in_valid = 1'b0;
    tick();

    // stall timeout with STALL_MAX=4, producer keeps offering a second word
    dst_en = 8'hFF; dst_ready = 8'h00;
    in_valid = 1'b1; in_data = 16'h5555; push(3, 16'h5555);
    tick();
    in_data = 16'hBEEF; push(3, 16'hBEEF);
    repeat (3) tick();
    check("stall3_err", err, 0);
    check("stall3_in_ready", in_ready, 0);
    tick();
    check("stall4_err", err, 1);
    check("stall4_busy", busy, 1);
    check("stall4_in_ready", in_ready, 0);
    check("stall4_out_data", out_data, 16'h5555);
    dst_ready = 8'h08;
    tick();
    in_valid = 1'b0;
    tick();
    check("post_stall_err", err, 1);
    check("post_stall_busy", busy, 0);

    // reset while holding a word
    dst_ready = 8'h00; in_valid = 1'b1; in_data = 16'h1234;
    tick();
    in_valid = 1'b0;
    tick();
    check("hold_busy", busy, 1);
    check("hold_out_data", out_data, 16'h1234);
    rst = 1'b1; dst_ready = 8'hFF; in_valid = 1'b1; in_data = 16'h9999;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_err", err, 0);
    check("midrst_in_ready", in_ready, 1);
    in_valid = 1'b1; in_data = 16'h7777; push(0, 16'h7777);
    tick();
    in_valid = 1'b0;
    tick(); tick();

    for (int i = 0; i < 20 && exp_port.size() != 0; i++) tick();
    check("scoreboard_empty", exp_port.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
